// File: rtl/bcd_scan_if.sv
// Handshake and display bus between a result producer and bcd_scan_display.
// The producer (master) issues start/hex_mode/value; the display block (slave)
// returns the conversion status, the digit codes and the scanned pin drive.
interface bcd_scan_if #(
    parameter int WIDTH = 13,
    parameter int NDIG  = 4
);
    logic                  start;
    logic                  hex_mode;
    logic [WIDTH-1:0]      value;
    logic                  busy;
    logic                  done;
    logic                  overflow;
    logic [4*NDIG-1:0]     digits;
    logic [6:0]            seg;
    logic [NDIG-1:0]       an;

    modport master (
        output start, hex_mode, value,
        input  busy, done, overflow, digits, seg, an
    );

    modport slave (
        input  start, hex_mode, value,
        output busy, done, overflow, digits, seg, an
    );
endinterface

// File: rtl/bcd_scan_display.sv
// Binary-to-decimal (or raw hex) converter feeding a time-multiplexed
// NDIG-digit 7-segment driver. Decimal conversion is iterative double dabble,
// one input bit per cycle; hex mode just copies nibbles. The scan runs
// continuously and always shows the current digits register.
//
// state  | meaning
// -------+--------------------------------------------------------------
// S_IDLE | waiting for start; digits register holds the last result
// S_CONV | conversion in flight (WIDTH cycles decimal, 1 cycle hex)
module bcd_scan_display #(
    parameter int WIDTH      = 13,
    parameter int NDIG       = 4,
    parameter int SCAN_DIV   = 4,
    parameter bit ACTIVE_LOW = 1'b0,
    parameter bit BLANK_LZ   = 1'b1
) (
    input  logic      clk,
    input  logic      rst,
    bcd_scan_if.slave bus
);
    localparam int DW     = 4 * NDIG;
    localparam int CNT_W  = $clog2(WIDTH + 1);
    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W  = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int HEX_B  = (WIDTH < DW) ? WIDTH : DW;

    // 65 bits so that 16^16 is still representable for the overflow limit.
    function automatic logic [64:0] ipow(input int base, input int n);
        logic [64:0] r;
        r = 65'd1;
        for (int i = 0; i < n; i++) r = r * 65'(base);
        return r;
    endfunction

    localparam logic [64:0] DEC_LIM = ipow(10, NDIG);
    localparam logic [64:0] HEX_LIM = ipow(16, NDIG);

    function automatic logic [6:0] glyph(input logic [3:0] code);
        logic [6:0] s;
        case (code)
            4'h0: s = 7'b1111110;
            4'h1: s = 7'b0110000;
            4'h2: s = 7'b1101101;
            4'h3: s = 7'b1111001;
            4'h4: s = 7'b0110011;
            4'h5: s = 7'b1011011;
            4'h6: s = 7'b1011111;
            4'h7: s = 7'b1110000;
            4'h8: s = 7'b1111111;
            4'h9: s = 7'b1111011;
            4'hA: s = 7'b1110111;
            4'hB: s = 7'b0011111;
            4'hC: s = 7'b1001110;
            4'hD: s = 7'b0111101;
            4'hE: s = 7'b1001111;
            default: s = 7'b1000111;
        endcase
        return s;
    endfunction

    typedef enum logic {
        S_IDLE = 1'b0,
        S_CONV = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic              hex_q, hex_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0]  shift_q, shift_d;
    logic [DW-1:0]     bcd_q, bcd_d;
    logic [DW-1:0]     digits_q, digits_d;
    logic              done_q, done_d;
    logic              ovf_q, ovf_d;
    logic [SCAN_W-1:0] scan_q, scan_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [6:0]        seg_q, seg_d;
    logic [NDIG-1:0]   an_q, an_d;

    logic [DW-1:0]     bcd_adj;
    logic [DW-1:0]     bcd_shift;
    logic [DW-1:0]     hex_val;
    logic              scan_wrap;
    logic [NDIG-1:0]   blank;
    logic              nz_above;
    logic [3:0]        sel_code;
    logic [6:0]        seg_raw;
    logic              unused_carry;

    // Top bit of the adjusted BCD word falls off the shift: value mod 10^NDIG.
    assign unused_carry = bcd_adj[DW-1];

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            hex_q    <= 1'b0;
            cnt_q    <= '0;
            shift_q  <= '0;
            bcd_q    <= '0;
            digits_q <= '0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
            scan_q   <= '0;
            idx_q    <= '0;
            seg_q    <= 7'b1111110 ^ {7{ACTIVE_LOW}};
            an_q     <= NDIG'(1) ^ {NDIG{ACTIVE_LOW}};
        end else begin
            state_q  <= state_d;
            hex_q    <= hex_d;
            cnt_q    <= cnt_d;
            shift_q  <= shift_d;
            bcd_q    <= bcd_d;
            digits_q <= digits_d;
            done_q   <= done_d;
            ovf_q    <= ovf_d;
            scan_q   <= scan_d;
            idx_q    <= idx_d;
            seg_q    <= seg_d;
            an_q     <= an_d;
        end
    end

    // Conversion FSM: accept, iterate double dabble (or copy hex), publish.
    always_comb begin
        state_d  = state_q;
        hex_d    = hex_q;
        cnt_d    = cnt_q;
        shift_d  = shift_q;
        bcd_d    = bcd_q;
        digits_d = digits_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;

        bcd_adj = bcd_q;
        for (int k = 0; k < NDIG; k++) begin
            if (bcd_q[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
        end
        bcd_shift = {bcd_adj[DW-2:0], shift_q[WIDTH-1]};

        hex_val = '0;
        for (int i = 0; i < HEX_B; i++) hex_val[i] = shift_q[i];

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_CONV;
                    hex_d   = bus.hex_mode;
                    shift_d = bus.value;
                    bcd_d   = '0;
                    cnt_d   = CNT_W'(WIDTH - 1);
                    ovf_d   = bus.hex_mode ? (65'(bus.value) >= HEX_LIM)
                                           : (65'(bus.value) >= DEC_LIM);
                end
            end
            S_CONV: begin
                if (hex_q) begin
                    digits_d = hex_val;
                    done_d   = 1'b1;
                    state_d  = S_IDLE;
                end else begin
                    bcd_d   = bcd_shift;
                    shift_d = shift_q << 1;
                    if (cnt_q == '0) begin
                        digits_d = bcd_shift;
                        done_d   = 1'b1;
                        state_d  = S_IDLE;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Scan timing plus segment/anode drive for the digit selected next cycle,
    // so seg and an change together on the same edge.
    always_comb begin
        scan_wrap = (scan_q == SCAN_W'(SCAN_DIV - 1));
        scan_d    = scan_wrap ? '0 : scan_q + 1'b1;
        idx_d     = idx_q;
        if (scan_wrap) idx_d = (idx_q == IDX_W'(NDIG - 1)) ? '0 : idx_q + 1'b1;

        nz_above = 1'b0;
        blank    = '0;
        for (int k = NDIG - 1; k >= 0; k--) begin
            nz_above = nz_above | (digits_q[4*k +: 4] != 4'd0);
            blank[k] = BLANK_LZ && (k != 0) && !nz_above;
        end

        sel_code = digits_q[4*idx_d +: 4];
        seg_raw  = blank[idx_d] ? 7'b0000000 : glyph(sel_code);
        seg_d    = seg_raw ^ {7{ACTIVE_LOW}};
        an_d     = (NDIG'(1) << idx_d) ^ {NDIG{ACTIVE_LOW}};
    end

    assign bus.busy     = (state_q == S_CONV);
    assign bus.done     = done_q;
    assign bus.overflow = ovf_q;
    assign bus.digits   = digits_q;
    assign bus.seg      = seg_q;
    assign bus.an       = an_q;
endmodule

// File: tb/tb_bcd_scan_display.sv
// Bench for bcd_scan_display: four builds (default, no blanking, active-low,
// 14-bit input) share one stimulus stream. A cycle-level reference model
// predicts results arithmetically; a scoreboard checks each done pulse.
module tb_bcd_scan_display;
    localparam int NDIG = 4;
    localparam int SD   = 4;
    localparam int WID [4] = '{13, 13, 13, 14};
    localparam bit BLZ [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    localparam bit AL  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    localparam logic [6:0] GLY [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        hex_mode = 1'b0;
    logic [13:0] value14 = '0;

    always #5 clk = ~clk;

    bcd_scan_if #(.WIDTH(13), .NDIG(4)) if0 ();
    bcd_scan_if #(.WIDTH(13), .NDIG(4)) if1 ();
    bcd_scan_if #(.WIDTH(13), .NDIG(4)) if2 ();
    bcd_scan_if #(.WIDTH(14), .NDIG(4)) if3 ();

    assign if0.start = start; assign if0.hex_mode = hex_mode; assign if0.value = value14[12:0];
    assign if1.start = start; assign if1.hex_mode = hex_mode; assign if1.value = value14[12:0];
    assign if2.start = start; assign if2.hex_mode = hex_mode; assign if2.value = value14[12:0];
    assign if3.start = start; assign if3.hex_mode = hex_mode; assign if3.value = value14;

    bcd_scan_display #(.WIDTH(13), .NDIG(4), .SCAN_DIV(4), .ACTIVE_LOW(1'b0), .BLANK_LZ(1'b1))
        u0 (.clk(clk), .rst(rst), .bus(if0));
    bcd_scan_display #(.WIDTH(13), .NDIG(4), .SCAN_DIV(4), .ACTIVE_LOW(1'b0), .BLANK_LZ(1'b0))
        u1 (.clk(clk), .rst(rst), .bus(if1));
    bcd_scan_display #(.WIDTH(13), .NDIG(4), .SCAN_DIV(4), .ACTIVE_LOW(1'b1), .BLANK_LZ(1'b1))
        u2 (.clk(clk), .rst(rst), .bus(if2));
    bcd_scan_display #(.WIDTH(14), .NDIG(4), .SCAN_DIV(4), .ACTIVE_LOW(1'b0), .BLANK_LZ(1'b1))
        u3 (.clk(clk), .rst(rst), .bus(if3));

    logic        busy_w [4];
    logic        done_w [4];
    logic        ovf_w  [4];
    logic [15:0] dig_w  [4];
    logic [6:0]  seg_w  [4];
    logic [3:0]  an_w   [4];

    assign busy_w[0] = if0.busy; assign done_w[0] = if0.done; assign ovf_w[0] = if0.overflow;
    assign busy_w[1] = if1.busy; assign done_w[1] = if1.done; assign ovf_w[1] = if1.overflow;
    assign busy_w[2] = if2.busy; assign done_w[2] = if2.done; assign ovf_w[2] = if2.overflow;
    assign busy_w[3] = if3.busy; assign done_w[3] = if3.done; assign ovf_w[3] = if3.overflow;
    assign dig_w[0] = if0.digits; assign seg_w[0] = if0.seg; assign an_w[0] = if0.an;
    assign dig_w[1] = if1.digits; assign seg_w[1] = if1.seg; assign an_w[1] = if1.an;
    assign dig_w[2] = if2.digits; assign seg_w[2] = if2.seg; assign an_w[2] = if2.an;
    assign dig_w[3] = if3.digits; assign seg_w[3] = if3.seg; assign an_w[3] = if3.an;

    typedef struct {
        logic [15:0] dig;
        bit          ovf;
        int          cyc;
    } exp_t;

    exp_t        sb [4][$];
    int          k_cnt = 0;
    int          m_rem [4] = '{0, 0, 0, 0};
    bit          m_ovf [4] = '{0, 0, 0, 0};
    bit          m_done[4] = '{0, 0, 0, 0};
    logic [15:0] m_dig [4] = '{16'h0, 16'h0, 16'h0, 16'h0};
    logic [15:0] prev_dig [4] = '{16'h0, 16'h0, 16'h0, 16'h0};
    logic [15:0] m_res [4] = '{16'h0, 16'h0, 16'h0, 16'h0};

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string nm, input int i, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s u%0d: got %0h, expected %0h (t=%0t)", nm, i, act, exp, $time);
    endtask

    function automatic logic [15:0] to_bcd(input int n);
        logic [15:0] r;
        int          x;
        r = '0;
        x = n;
        for (int j = 0; j < 4; j++) begin
            r[4*j +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [6:0] exp_seg(input int i, input logic [15:0] d, input int idx);
        logic [6:0] s;
        int         rest;
        rest = int'(d) >> (4 * idx);
        if (BLZ[i] && idx > 0 && rest == 0) s = 7'b0000000;
        else s = GLY[rest % 16];
        if (AL[i]) s = ~s;
        return s;
    endfunction

    function automatic logic [3:0] exp_an(input int i, input int idx);
        logic [3:0] a;
        a = 4'(1 << idx);
        if (AL[i]) a = ~a;
        return a;
    endfunction

    // Reference model: value arithmetic and conversion latency, per build.
    always @(posedge clk or posedge rst) begin
        int v;
        if (rst) begin
            k_cnt = 0;
            for (int i = 0; i < 4; i++) begin
                m_rem[i] = 0; m_ovf[i] = 0; m_done[i] = 0;
                m_dig[i] = '0; prev_dig[i] = '0; m_res[i] = '0;
                sb[i].delete();
            end
        end else begin
            k_cnt++;
            for (int i = 0; i < 4; i++) begin
                prev_dig[i] = m_dig[i];
                m_done[i]   = 0;
                if (m_rem[i] > 0) begin
                    m_rem[i]--;
                    if (m_rem[i] == 0) begin
                        m_dig[i]  = m_res[i];
                        m_done[i] = 1;
                    end
                end else if (start) begin
                    v = int'(value14) % (1 << WID[i]);
                    if (hex_mode) begin
                        m_res[i] = 16'(v % 65536);
                        m_ovf[i] = (v >= 65536);
                        m_rem[i] = 1;
                    end else begin
                        m_res[i] = to_bcd(v % 10000);
                        m_ovf[i] = (v >= 10000);
                        m_rem[i] = WID[i];
                    end
                    sb[i].push_back('{m_res[i], m_ovf[i], k_cnt + m_rem[i]});
                end
            end
        end
    end

    // Monitor: per-cycle status/display checks and scoreboard pop on done.
    always @(negedge clk) begin
        int   idx;
        exp_t e;
        idx = (k_cnt / SD) % NDIG;
        for (int i = 0; i < 4; i++) begin
            check("busy", i, busy_w[i], m_rem[i] > 0);
            check("done", i, done_w[i], m_done[i]);
            check("overflow", i, ovf_w[i], m_ovf[i]);
            check("digits", i, dig_w[i], m_dig[i]);
            check("an", i, an_w[i], exp_an(i, idx));
            check("seg", i, seg_w[i], exp_seg(i, prev_dig[i], idx));
            if (done_w[i]) begin
                check("sb_pending", i, sb[i].size() > 0, 1);
                if (sb[i].size() > 0) begin
                    e = sb[i].pop_front();
                    check("sb_digits", i, dig_w[i], e.dig);
                    check("sb_overflow", i, ovf_w[i], e.ovf);
                    check("sb_latency", i, k_cnt, e.cyc);
                end
            end
        end
    end

    function automatic bit all_idle();
        bit r;
        r = 1;
        for (int i = 0; i < 4; i++) if (m_rem[i] != 0 || busy_w[i]) r = 0;
        return r;
    endfunction

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int n = 0; n < 100 && !ok; n++) begin
            @(negedge clk);
            ok = all_idle();
        end
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL idle_timeout: busy still %0b after 100 cycles, required 0", busy_w[0]);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic issue(input int v, input bit hx, input int hold);
        @(negedge clk);
        value14  = 14'(v);
        hex_mode = hx;
        start    = 1'b1;
        repeat (hold) @(negedge clk);
        start    = 1'b0;
    endtask

    initial begin
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        wait_cycles(20);

        issue(1234, 1'b0, 1); wait_idle(); wait_cycles(20);
        issue(42, 1'b0, 1);   wait_idle(); wait_cycles(20);
        issue(9999, 1'b0, 1); wait_idle(); wait_cycles(4);
        issue(10000, 1'b0, 1); wait_idle(); wait_cycles(20);
        issue(16'h0ABC, 1'b1, 1); wait_idle(); wait_cycles(20);

        issue(5678, 1'b0, 1);
        wait_cycles(2);
        issue(321, 1'b0, 1);
        wait_cycles(3);
        issue(77, 1'b1, 1);
        wait_idle(); wait_cycles(20);

        issue(12000, 1'b0, 1);
        wait_cycles(4);
        #1 rst = 1'b1;
        #1;
        check("rst_busy", 0, if0.busy, 0);
        check("rst_done", 0, if0.done, 0);
        check("rst_digits", 0, if0.digits, 0);
        check("rst_overflow", 3, if3.overflow, 0);
        check("rst_an", 0, if0.an, 4'b0001);
        check("rst_seg", 0, if0.seg, 7'b1111110);
        check("rst_an_al", 2, if2.an, 4'b1110);
        check("rst_seg_al", 2, if2.seg, 7'b0000001);
        wait_cycles(2);
        rst = 1'b0;
        wait_cycles(20);

        issue(0, 1'b0, 1);    wait_idle(); wait_cycles(6);
        issue(8191, 1'b0, 1); wait_idle(); wait_cycles(6);
        issue(0, 1'b1, 1);    wait_idle(); wait_cycles(6);

        for (int n = 0; n < 40; n++) begin
            issue(int'($urandom_range(16383, 0)), ($urandom_range(3, 0) == 0),
                  int'($urandom_range(3, 1)));
            wait_cycles(int'($urandom_range(20, 0)));
        end

        wait_idle();
        wait_cycles(5);
        for (int i = 0; i < 4; i++) check("sb_leftover", i, sb[i].size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
